ram_bus_bridge: RTL and testbench
=================================

# ram_bus_bridge

Downstream neighbour of the memory controller: converts its single-port RAM request (`Ren`/`Wen`/`ramaddr`/`ramstore`) into one Wishbone-style classic-cycle bus transaction and reports completion back through `busy_o`/`ramload`. One transaction is in flight at a time. Address, data and direction are latched at launch, so upstream changes mid-transaction have no effect.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus-watchdog limit in cycles. Range 1–1023; used only when the watchdog is compiled in.
- `CLK` in 1: the single clock; all logic uses its rising edge.
- `nRST` in 1: reset, asynchronous assert, active-low.
- `Ren` in 1: read request from the memory controller.
- `Wen` in 1: write request from the memory controller.
- `ramaddr` in 32: byte address of the request.
- `ramstore` in 32: write data.
- `ramload` out 32: read data. Holds its value until the next read completes.
- `busy_o` out 1: 0 for exactly one cycle when the accepted transaction completes; 1 otherwise.
- `err_o` out 1: one-cycle pulse, coincident with `busy_o`=0, when the transaction timed out.
- `cyc_o` out 1: bus cycle active.
- `stb_o` out 1: bus strobe. Always equal to `cyc_o`.
- `we_o` out 1: bus write enable, latched.
- `adr_o` out 32: bus address, latched.
- `dat_o` out 32: bus write data, latched.
- `dat_i` in 32: bus read data. Valid when `ack_i`=1.
- `ack_i` in 1: bus acknowledge.

## Operation
- The block has three states: IDLE, BUS and RESP.
- **IDLE**:
  - If `Ren` or `Wen` is 1, latch `adr_o`←`ramaddr` and `dat_o`←`ramstore`, then go to BUS.
  - `we_o` ← `Wen & ~Ren`. When both requests are high, the read wins.
  - If neither request is high, stay in IDLE.
  - `ack_i` is ignored.
- **BUS**:
  - `cyc_o`=`stb_o`=1.
  - On `ack_i`=1: if `we_o`=0, `ramload`←`dat_i`. Then go to RESP.
  - If `Ren`/`Wen` drop while in BUS, the transaction still completes normally.
- **RESP**:
  - `busy_o`=0 and `cyc_o`=0, then unconditionally go to IDLE.
  - `ack_i` is ignored.
- Back-to-back requests: a request held high in the cycle after RESP is treated as a new transaction. Upstream must drop or change the request on the `busy_o`=0 cycle.
- Reset, including mid-transaction, produces:
  - state = IDLE;
  - `cyc_o`=`stb_o`=`we_o`=0;
  - `adr_o`=`dat_o`=`ramload`=0;
  - `busy_o`=1, `err_o`=0.
  - Bus strobes drop asynchronously with `nRST`.

## Timing
- All outputs are registered or state-decoded; there is no combinational path from inputs to outputs.
- Launch: request sampled at edge N → `cyc_o`=1 from edge N.
- Completion: `ack_i` sampled at edge M → RESP from edge M, i.e. `busy_o`=0 for the cycle M..M+1.
- Minimum transaction, with `ack_i` in the first BUS cycle: request-to-`busy_o`=0 is 2 cycles, then 1 cycle in IDLE.
- `ramload` is updated at the same edge that enters RESP, so it is valid throughout the `busy_o`=0 cycle.
- `busy_o` is 1 while IDLE, even with no request pending. Upstream qualifies it with its own request.

## Configuration
- **`RAM_BUS_TIMEOUT_EN` defined**:
  - A 10-bit counter clears on entry to BUS and increments each BUS cycle without `ack_i`.
  - When the counter reaches `TIMEOUT_CYCLES`, the block goes to RESP with `err_o`=1 and `ramload`←32'hBAD1_BAD1 (reads and writes alike).
  - `ack_i` arriving in the same cycle as the limit wins: normal completion, `err_o`=0.
- **Not defined**:
  - BUS waits indefinitely for `ack_i`.
  - `err_o` is constant 0 and no counter exists.

## Test plan
- Reset mid-BUS (`cyc_o`=1), with `nRST` pulled low between edges → `cyc_o`/`stb_o` drop immediately; `busy_o`=1; `ramload`=0; state is IDLE after `nRST` releases.
- Read: `Ren`=1, `ramaddr`=0x0000_0040, slave `ack_i` after 3 cycles with `dat_i`=0x1234_5678 → `adr_o`=0x40, `we_o`=0, `busy_o`=0 for one cycle with `ramload`=0x1234_5678.
- Write: `Wen`=1, `ramaddr`=0x80, `ramstore`=0xCAFE_F00D, `ack_i` in the first BUS cycle → `we_o`=1, `dat_o`=0xCAFE_F00D; `busy_o`=0 exactly 2 cycles after the request; `ramload` unchanged.
- Simultaneous `Ren`=`Wen`=1; `ramaddr` changed to 0x99 during BUS; `Ren` dropped before `ack_i` → `we_o`=0, `adr_o` keeps its launch value, transaction completes, one `busy_o`=0 pulse.
- Back-to-back: read to 0x0 then write to 0x4, each presented on the cycle after `busy_o`=0 → two distinct bus cycles separated by one idle cycle (`cyc_o`=0 in RESP).
- With `RAM_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4 and `ack_i` held 0 → `err_o`=1 and `busy_o`=0 after 4 BUS cycles, `ramload`=0xBAD1_BAD1. Separately, `ack_i` on the 4th cycle → `err_o`=0.

Source files
------------

// File: rtl/ram_bus_bridge.sv
// ram_bus_bridge: turns one memory-controller RAM request into one classic-cycle bus transaction.
// Optional bus watchdog is compiled in when RAM_BUS_TIMEOUT_EN is defined.
module ram_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        Ren,
   input  logic        Wen,
   input  logic [31:0] ramaddr,
   input  logic [31:0] ramstore,
   output logic [31:0] ramload,
   output logic        busy_o,
   output logic        err_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [31:0] adr_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hBAD1_BAD1;

   // Reject out-of-range watchdog limits at elaboration.
   generate
      if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
         $error("ram_bus_bridge: TIMEOUT_CYCLES must be in 1..1023");
      end
   endgenerate

   logic [1:0]        state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic [DATA_W-1:0] ramload_q, ramload_d;
   logic              req;
   logic              timeout_hit;

   assign req = Ren | Wen;

`ifdef RAM_BUS_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             err_q, err_d;

   assign cnt_inc     = cnt_q + CNT_W'(1);
   // The limit is reached on the cycle whose missing ack would bring the count to TIMEOUT_CYCLES.
   assign timeout_hit = (state_q == ST_BUS) && !ack_i && (cnt_inc == TIMEOUT_LIMIT);

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE && req) begin
         cnt_d = '0;
      end else if (state_q == ST_BUS && !ack_i) begin
         cnt_d = cnt_inc;
      end
   end

   assign err_d = timeout_hit;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err_o       = 1'b0;
`endif

   // Next-state and latched bus/response values.
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      ramload_d = ramload_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d = ST_BUS;
               adr_d   = ramaddr;
               dat_d   = ramstore;
               we_d    = Wen & ~Ren;
            end
         end
         ST_BUS: begin
            if (ack_i) begin
               if (!we_q) begin
                  ramload_d = dat_i;
               end
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               ramload_d = TIMEOUT_DATA;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= ST_IDLE;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         ramload_q <= '0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         ramload_q <= ramload_d;
      end
   end

   // Strobes and busy are decoded from the state register, so they follow nRST asynchronously.
   assign cyc_o   = (state_q == ST_BUS);
   assign stb_o   = (state_q == ST_BUS);
   assign busy_o  = (state_q != ST_RESP);
   assign we_o    = we_q;
   assign adr_o   = adr_q;
   assign dat_o   = dat_q;
   assign ramload = ramload_q;

endmodule

// File: tb/tb_ram_bus_bridge.sv
// tb_ram_bus_bridge: scoreboard-driven bench for ram_bus_bridge; define RAM_BUS_TIMEOUT_EN to cover the watchdog.
module tb_ram_bus_bridge;

`ifdef RAM_BUS_TIMEOUT_EN
   localparam int unsigned TO = 4;
`else
   localparam int unsigned TO = 255;
`endif

   logic        CLK = 1'b0;
   logic        nRST;
   logic        Ren, Wen;
   logic [31:0] ramaddr, ramstore, ramload;
   logic        busy_o, err_o, cyc_o, stb_o, we_o;
   logic [31:0] adr_o, dat_o, dat_i;
   logic        ack_i;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] adr;
      logic        we;
      logic [31:0] dat;
      logic [31:0] load;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_load;

   ram_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
      .CLK(CLK), .nRST(nRST), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .busy_o(busy_o), .err_o(err_o), .cyc_o(cyc_o), .stb_o(stb_o),
      .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Drive one request and play the slave; returns what the bus and response showed.
   task automatic do_txn(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ack_after, input int budget,
                         output logic [31:0] o_adr, output logic o_we, output logic [31:0] o_dat,
                         output logic [31:0] o_load, output logic o_err, output int o_lat,
                         output logic o_timeout);
      int bus_n;
      Ren = ren; Wen = wen; ramaddr = addr; ramstore = wdata;
      tick;
      o_lat = 1;
      o_adr = adr_o; o_we = we_o; o_dat = dat_o;
      Ren = 1'b0; Wen = 1'b0; ramaddr = 32'h0000_0099; ramstore = 32'h7777_7777;
      bus_n = 0;
      o_timeout = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (busy_o === 1'b0) begin
            o_timeout = 1'b0;
            break;
         end
         if (ack_after >= 0 && bus_n == ack_after) begin
            ack_i = 1'b1; dat_i = rdata;
         end else begin
            ack_i = 1'b0; dat_i = $urandom;
         end
         tick;
         o_lat++;
         bus_n++;
         ack_i = 1'b0;
      end
      o_load = ramload;
      o_err  = err_o;
   endtask

   task automatic test_reset;
      nRST = 1'b0; Ren = 1'b0; Wen = 1'b0; ramaddr = '0; ramstore = '0; ack_i = 1'b0; dat_i = '0;
      #12;
      checks++; if (busy_o !== 1'b1 || cyc_o !== 1'b0 || stb_o !== 1'b0) begin failures++;
         $display("FAIL reset_ctl busy=%b cyc=%b stb=%b required 1 0 0", busy_o, cyc_o, stb_o); end
      checks++; if (we_o !== 1'b0 || adr_o !== 32'h0 || dat_o !== 32'h0 || ramload !== 32'h0 || err_o !== 1'b0) begin failures++;
         $display("FAIL reset_data we=%b adr=%h dat=%h load=%h err=%b required all 0", we_o, adr_o, dat_o, ramload, err_o); end
      @(negedge CLK); nRST = 1'b1;
      model_load = 32'h0;
      // ack_i in IDLE must be ignored
      ack_i = 1'b1; dat_i = 32'hDEAD_0000;
      tick; tick;
      checks++; if (busy_o !== 1'b1 || cyc_o !== 1'b0 || ramload !== 32'h0) begin failures++;
         $display("FAIL idle_ack busy=%b cyc=%b load=%h required 1 0 0", busy_o, cyc_o, ramload); end
      ack_i = 1'b0;
   endtask

   task automatic test_read;
      logic [31:0] a, d, l; logic w, e, to; int lat; exp_t x;
      sb.push_back('{adr: 32'h40, we: 1'b0, dat: 32'h1111_2222, load: 32'h1234_5678, err: 1'b0, lat: 5});
      do_txn(1'b1, 1'b0, 32'h40, 32'h1111_2222, 32'h1234_5678, 3, 50, a, w, d, l, e, lat, to);
      x = sb.pop_front(); model_load = x.load;
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL read_done timeout=%b required 0", to); end
      checks++; if (a !== x.adr || w !== x.we) begin failures++;
         $display("FAIL read_bus adr=%h we=%b required %h %b", a, w, x.adr, x.we); end
      checks++; if (l !== x.load || e !== x.err || lat !== x.lat) begin failures++;
         $display("FAIL read_resp load=%h err=%b lat=%0d required %h %b %0d", l, e, lat, x.load, x.err, x.lat); end
      tick;
      checks++; if (busy_o !== 1'b1 || cyc_o !== 1'b0) begin failures++;
         $display("FAIL read_pulse busy=%b cyc=%b required 1 0", busy_o, cyc_o); end
   endtask

   task automatic test_write;
      logic [31:0] a, d, l; logic w, e, to; int lat; exp_t x;
      sb.push_back('{adr: 32'h80, we: 1'b1, dat: 32'hCAFE_F00D, load: model_load, err: 1'b0, lat: 2});
      do_txn(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 32'h5555_AAAA, 0, 50, a, w, d, l, e, lat, to);
      x = sb.pop_front();
      checks++; if (to !== 1'b0 || lat !== x.lat) begin failures++;
         $display("FAIL write_lat timeout=%b lat=%0d required 0 %0d", to, lat, x.lat); end
      checks++; if (a !== x.adr || w !== x.we || d !== x.dat) begin failures++;
         $display("FAIL write_bus adr=%h we=%b dat=%h required %h %b %h", a, w, d, x.adr, x.we, x.dat); end
      checks++; if (l !== x.load || e !== x.err) begin failures++;
         $display("FAIL write_resp load=%h err=%b required %h %b", l, e, x.load, x.err); end
      tick;
   endtask

   task automatic test_both;
      logic [31:0] a, d, l; logic w, e, to; int lat; exp_t x;
      sb.push_back('{adr: 32'h10, we: 1'b0, dat: 32'h55, load: 32'hA5A5_0001, err: 1'b0, lat: 4});
      do_txn(1'b1, 1'b1, 32'h10, 32'h55, 32'hA5A5_0001, 2, 50, a, w, d, l, e, lat, to);
      x = sb.pop_front(); model_load = x.load;
      checks++; if (to !== 1'b0 || w !== x.we || lat !== x.lat) begin failures++;
         $display("FAIL both_dir timeout=%b we=%b lat=%0d required 0 %b %0d", to, w, lat, x.we, x.lat); end
      checks++; if (adr_o !== x.adr || dat_o !== x.dat) begin failures++;
         $display("FAIL both_latch adr=%h dat=%h required %h %h", adr_o, dat_o, x.adr, x.dat); end
      checks++; if (l !== x.load) begin failures++;
         $display("FAIL both_load load=%h required %h", l, x.load); end
      tick;
      checks++; if (busy_o !== 1'b1) begin failures++;
         $display("FAIL both_pulse busy=%b required 1", busy_o); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, d, l; logic w, e, to; int lat; exp_t x;
      sb.push_back('{adr: 32'h0, we: 1'b0, dat: 32'h0, load: 32'hDEAD_BEEF, err: 1'b0, lat: 2});
      sb.push_back('{adr: 32'h4, we: 1'b1, dat: 32'h0BAD_CAFE, load: 32'hDEAD_BEEF, err: 1'b0, lat: 3});
      for (int k = 0; k < 2; k++) begin
         if (k == 0) do_txn(1'b1, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 50, a, w, d, l, e, lat, to);
         else        do_txn(1'b0, 1'b1, 32'h4, 32'h0BAD_CAFE, 32'h1, 1, 50, a, w, d, l, e, lat, to);
         x = sb.pop_front(); model_load = x.load;
         checks++; if (to !== 1'b0 || cyc_o !== 1'b0) begin failures++;
            $display("FAIL b2b_resp%0d timeout=%b cyc=%b required 0 0", k, to, cyc_o); end
         checks++; if (a !== x.adr || w !== x.we || d !== x.dat || l !== x.load || lat !== x.lat) begin failures++;
            $display("FAIL b2b_txn%0d adr=%h we=%b dat=%h load=%h lat=%0d required %h %b %h %h %0d",
                     k, a, w, d, l, lat, x.adr, x.we, x.dat, x.load, x.lat); end
         tick;
         checks++; if (busy_o !== 1'b1 || cyc_o !== 1'b0) begin failures++;
            $display("FAIL b2b_idle%0d busy=%b cyc=%b required 1 0", k, busy_o, cyc_o); end
      end
   endtask

   task automatic test_reset_mid;
      Ren = 1'b1; ramaddr = 32'h200;
      tick;
      Ren = 1'b0; ack_i = 1'b0;
      tick;
      checks++; if (cyc_o !== 1'b1 || stb_o !== 1'b1) begin failures++;
         $display("FAIL mid_bus cyc=%b stb=%b required 1 1", cyc_o, stb_o); end
      #2; nRST = 1'b0; #1;
      checks++; if (cyc_o !== 1'b0 || stb_o !== 1'b0 || busy_o !== 1'b1) begin failures++;
         $display("FAIL mid_async cyc=%b stb=%b busy=%b required 0 0 1", cyc_o, stb_o, busy_o); end
      checks++; if (ramload !== 32'h0 || adr_o !== 32'h0 || we_o !== 1'b0 || err_o !== 1'b0) begin failures++;
         $display("FAIL mid_data load=%h adr=%h we=%b err=%b required 0 0 0 0", ramload, adr_o, we_o, err_o); end
      #2; nRST = 1'b1;
      model_load = 32'h0;
      tick;
      checks++; if (cyc_o !== 1'b0 || busy_o !== 1'b1) begin failures++;
         $display("FAIL mid_idle cyc=%b busy=%b required 0 1", cyc_o, busy_o); end
   endtask

`ifdef RAM_BUS_TIMEOUT_EN
   task automatic test_timeout;
      logic [31:0] a, d, l; logic w, e, to; int lat; exp_t x;
      sb.push_back('{adr: 32'h300, we: 1'b1, dat: 32'h1, load: 32'hBAD1_BAD1, err: 1'b1, lat: 5});
      sb.push_back('{adr: 32'h304, we: 1'b0, dat: 32'h2, load: 32'h600D_600D, err: 1'b0, lat: 5});
      for (int k = 0; k < 2; k++) begin
         if (k == 0) do_txn(1'b0, 1'b1, 32'h300, 32'h1, 32'h0, -1, 20, a, w, d, l, e, lat, to);
         else        do_txn(1'b1, 1'b0, 32'h304, 32'h2, 32'h600D_600D, 3, 20, a, w, d, l, e, lat, to);
         x = sb.pop_front(); model_load = x.load;
         checks++; if (to !== 1'b0 || lat !== x.lat) begin failures++;
            $display("FAIL wd_lat%0d timeout=%b lat=%0d required 0 %0d", k, to, lat, x.lat); end
         checks++; if (e !== x.err || l !== x.load) begin failures++;
            $display("FAIL wd_resp%0d err=%b load=%h required %b %h", k, e, l, x.err, x.load); end
         tick;
         checks++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin failures++;
            $display("FAIL wd_pulse%0d err=%b busy=%b required 0 1", k, err_o, busy_o); end
      end
   endtask
`else
   task automatic test_timeout;
      logic [31:0] a, d, l; logic w, e, to; int lat;
      // Without the watchdog a slow slave is simply waited for.
      do_txn(1'b1, 1'b0, 32'h300, 32'h0, 32'h5107_5107, 300, 400, a, w, d, l, e, lat, to);
      model_load = 32'h5107_5107;
      checks++; if (to !== 1'b0 || lat !== 302) begin failures++;
         $display("FAIL slow_lat timeout=%b lat=%0d required 0 302", to, lat); end
      checks++; if (e !== 1'b0 || l !== model_load) begin failures++;
         $display("FAIL slow_resp err=%b load=%h required 0 %h", e, l, model_load); end
      tick;
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL global_timeout sim time exceeded");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset;
      test_read;
      test_write;
      test_both;
      test_back_to_back;
      test_reset_mid;
      test_timeout;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
